// File: rtl/pong_board_pkg.sv
// Shared board types, geometry constants and scan FSM states for the LED matrix driver.
package pong_board_pkg;

  localparam int NUM_ROWS  = 8;
  localparam int ROW_BITS  = 24;
  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 16;

  typedef logic [ROW_BITS-1:0]               board_row_t;
  typedef logic [NUM_ROWS-1:0][ROW_BITS-1:0] board_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } scan_state_t;

  // Packs one row's red/green/blue column bytes into the row word layout.
  function automatic board_row_t make_row(input logic [7:0] red,
                                          input logic [7:0] green,
                                          input logic [7:0] blue);
    board_row_t row;
    row = '0;
    row[RED_LSB   +: 8] = red;
    row[GREEN_LSB +: 8] = green;
    row[BLUE_LSB  +: 8] = blue;
    return row;
  endfunction

endpackage

// File: rtl/board_scan_driver_if.sv
// Bundle between the board logic (master) and the scan driver (slave): image in, matrix pins out.
interface board_scan_driver_if;
  import pong_board_pkg::*;

  logic       enable;
  board_t     board;
  logic       ser_data;
  logic       ser_clk;
  logic       ser_latch;
  logic [7:0] row_sel;
  logic       frame_done;
  logic       busy;

  modport master (
    output enable, board,
    input  ser_data, ser_clk, ser_latch, row_sel, frame_done, busy
  );

  modport slave (
    input  enable, board,
    output ser_data, ser_clk, ser_latch, row_sel, frame_done, busy
  );

endinterface

// File: rtl/board_row_serializer.sv
// Shifts one 24-bit row word out MSB first: each bit is CLK_DIV cycles with ser_clk low,
// then CLK_DIV cycles with ser_clk high; done flags the final cycle of the last bit.
module board_row_serializer
  import pong_board_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  board_row_t word,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       done
);

  localparam int              PH_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [4:0]      BIT_LAST = 5'(ROW_BITS - 1);

  board_row_t      shreg_q;
  logic [4:0]      bit_q;
  logic [PH_W-1:0] phase_q;
  logic            half_q;
  logic            active_q;
  logic            phase_end;

  assign phase_end = (phase_q == PH_LAST);

  // Load a new word, then step phase -> half-bit -> bit, shifting after each high half.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset) begin
      shreg_q  <= '0;
      bit_q    <= '0;
      phase_q  <= '0;
      half_q   <= 1'b0;
      active_q <= 1'b0;
    end else if (load) begin
      shreg_q  <= word;
      bit_q    <= '0;
      phase_q  <= '0;
      half_q   <= 1'b0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (!phase_end) begin
        phase_q <= phase_q + 1'b1;
      end else begin
        phase_q <= '0;
        half_q  <= ~half_q;
        if (half_q) begin
          shreg_q <= {shreg_q[ROW_BITS-2:0], 1'b0};
          if (bit_q == BIT_LAST) active_q <= 1'b0;
          else                   bit_q    <= bit_q + 1'b1;
        end
      end
    end
  end

  // Zero fill means the register is empty after 24 shifts, so ser_data idles low between rows.
  assign ser_data = shreg_q[ROW_BITS-1];
  assign ser_clk  = half_q;
  assign done     = active_q & half_q & phase_end & (bit_q == BIT_LAST);

endmodule

// File: rtl/board_scan_driver.sv
// Scans an 8x24 RGB board image onto the LED matrix one row at a time:
// load, serialise, latch, then enable the row for HOLD_CYCLES. Row 0 snapshots the frame.
module board_scan_driver
  import pong_board_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int HOLD_CYCLES = 1000
) (
  input logic                clock,
  input logic                reset,
  board_scan_driver_if.slave bus
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  scan_state_t       state_q, state_d;
  logic [2:0]        row_q, row_d;
  board_t            frame_q;
  logic [HOLD_W-1:0] hold_q;
  logic              hold_end;
  logic [7:0]        row_sel_q;
  logic              ser_latch_q;
  logic              frame_done_q;
  logic              busy_q;
  logic              load;
  board_row_t        load_word;
  logic              ser_done;
  logic              ser_data;
  logic              ser_clk;

  assign hold_end  = (hold_q == HOLD_LAST);
  assign load      = (state_q == LOAD);
  // Row 0 reads the live board because the snapshot is being taken in that same cycle.
  assign load_word = (row_q == 3'd0) ? bus.board[0] : frame_q[row_q];

  // Next-state and next-row selection.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = LOAD;
          row_d   = 3'd0;
        end
      end
      LOAD:  state_d = SHIFT;
      SHIFT: if (ser_done) state_d = LATCH;
      LATCH: state_d = HOLD;
      HOLD: begin
        if (hold_end) begin
          row_d = row_q + 3'd1;
          if (row_q != 3'd7) state_d = LOAD;
          else               state_d = bus.enable ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, hold counter and registered outputs derived from the upcoming state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      hold_q       <= '0;
      row_sel_q    <= 8'h00;
      ser_latch_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      hold_q       <= (state_q == HOLD && !hold_end) ? hold_q + 1'b1 : '0;
      row_sel_q    <= (state_d == HOLD) ? (8'd1 << row_d) : 8'h00;
      ser_latch_q  <= (state_d == LATCH);
      frame_done_q <= (state_q == HOLD) && hold_end && (row_q == 3'd7);
      busy_q       <= (state_d != IDLE);
    end
  end

  // Frame snapshot taken when row 0 loads.
  always_ff @(posedge clock) begin
    // NOTE: frame_q has no reset; it is always rewritten at row 0 before rows 1..7 read it.
    if (load && row_q == 3'd0) frame_q <= bus.board;
  end

  board_row_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_serializer (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .word     (load_word),
    .ser_data (ser_data),
    .ser_clk  (ser_clk),
    .done     (ser_done)
  );

  assign bus.ser_data   = ser_data;
  assign bus.ser_clk    = ser_clk;
  assign bus.ser_latch  = ser_latch_q;
  assign bus.row_sel    = row_sel_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_board_scan_driver.sv
// Directed bench: dut_a (CLK_DIV=1, HOLD=4) covers reset, snapshot and enable handling;
// dut_b (CLK_DIV=3, HOLD=4) covers ser_clk phase timing and data stability.
module tb_board_scan_driver;
  import pong_board_pkg::*;

  logic clock = 1'b0;
  logic reset_a;
  logic reset_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clock = ~clock;

  board_scan_driver_if bus_a ();
  board_scan_driver_if bus_b ();

  board_scan_driver #(.CLK_DIV(1), .HOLD_CYCLES(4)) dut_a (
    .clock (clock), .reset (reset_a), .bus (bus_a)
  );
  board_scan_driver #(.CLK_DIV(3), .HOLD_CYCLES(4)) dut_b (
    .clock (clock), .reset (reset_b), .bus (bus_b)
  );

  localparam logic [23:0] OLD_ROWS [8] = '{24'h010101, 24'h020202, 24'h040404, 24'h080808,
                                           24'h101010, 24'h202020, 24'h404040, 24'h808080};
  localparam logic [23:0] NEW_ROWS [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hAAAAAA,
                                           24'h555555, 24'h123456, 24'hABCDEF, 24'h0F0F0F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // ---------------- monitor for dut_a ----------------
  int          cyc_a = 0;
  logic        prev_clk_a = 1'b0, prev_latch_a = 1'b0;
  logic [23:0] acc_a = '0;
  int          nbits_a = 0;
  logic [23:0] lat_word_a [$];
  int          lat_bits_a [$];
  int          lat_cyc_a  [$];
  logic [7:0]  run_sel_a  [$];
  int          run_len_a  [$];
  logic [7:0]  cur_sel_a = 8'h00;
  int          cur_len_a = 0;
  int          fd_cyc_a   [$];
  int          multi_a = 0, latch_long_a = 0;

  always @(negedge clock) begin
    cyc_a++;
    if (bus_a.ser_clk && !prev_clk_a) begin
      acc_a = {acc_a[22:0], bus_a.ser_data};
      nbits_a++;
    end
    prev_clk_a = bus_a.ser_clk;
    if (bus_a.ser_latch) begin
      if (prev_latch_a) latch_long_a++;
      else begin
        lat_word_a.push_back(acc_a);
        lat_bits_a.push_back(nbits_a);
        lat_cyc_a.push_back(cyc_a);
      end
      acc_a   = '0;
      nbits_a = 0;
    end
    prev_latch_a = bus_a.ser_latch;
    if ($countones(bus_a.row_sel) > 1) multi_a++;
    if (bus_a.row_sel != cur_sel_a) begin
      if (cur_sel_a != 8'h00) begin
        run_sel_a.push_back(cur_sel_a);
        run_len_a.push_back(cur_len_a);
      end
      cur_sel_a = bus_a.row_sel;
      cur_len_a = 1;
    end else if (cur_sel_a != 8'h00) begin
      cur_len_a++;
    end
    if (bus_a.frame_done) fd_cyc_a.push_back(cyc_a);
  end

  task automatic clear_a();
    lat_word_a.delete(); lat_bits_a.delete(); lat_cyc_a.delete();
    run_sel_a.delete();  run_len_a.delete();  fd_cyc_a.delete();
    acc_a = '0; nbits_a = 0; cur_sel_a = 8'h00; cur_len_a = 0;
    multi_a = 0; latch_long_a = 0;
  endtask

  function automatic logic [31:0] lw_a(input int i);
    return (i < lat_word_a.size()) ? 32'(lat_word_a[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int lb_a(input int i);
    return (i < lat_bits_a.size()) ? lat_bits_a[i] : -1;
  endfunction
  function automatic int lc_a(input int i);
    return (i < lat_cyc_a.size()) ? lat_cyc_a[i] : -1000;
  endfunction
  function automatic logic [31:0] rs_a(input int i);
    return (i < run_sel_a.size()) ? 32'(run_sel_a[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int rl_a(input int i);
    return (i < run_len_a.size()) ? run_len_a[i] : -1;
  endfunction
  function automatic int fd_a(input int i);
    return (i < fd_cyc_a.size()) ? fd_cyc_a[i] : -1000;
  endfunction

  task automatic wait_lat_a(input int n, input int budget, input string tag);
    int k = 0;
    while (lat_word_a.size() < n && k < budget) begin tick(); k++; end
    check({tag, "_seen"}, 32'(lat_word_a.size() >= n), 32'd1);
  endtask
  task automatic wait_run_a(input int n, input int budget, input string tag);
    int k = 0;
    while (run_sel_a.size() < n && k < budget) begin tick(); k++; end
    check({tag, "_seen"}, 32'(run_sel_a.size() >= n), 32'd1);
  endtask
  task automatic wait_fd_a(input int n, input int budget, input string tag);
    int k = 0;
    while (fd_cyc_a.size() < n && k < budget) begin tick(); k++; end
    check({tag, "_seen"}, 32'(fd_cyc_a.size() >= n), 32'd1);
  endtask
  task automatic wait_sel_a(input logic [7:0] val, input int budget, input string tag);
    int k = 0;
    while (bus_a.row_sel != val && k < budget) begin tick(); k++; end
    check({tag, "_seen"}, 32'(bus_a.row_sel), 32'(val));
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_ser_data"},   32'(bus_a.ser_data),   32'd0);
    check({tag, "_ser_clk"},    32'(bus_a.ser_clk),    32'd0);
    check({tag, "_ser_latch"},  32'(bus_a.ser_latch),  32'd0);
    check({tag, "_row_sel"},    32'(bus_a.row_sel),    32'd0);
    check({tag, "_frame_done"}, 32'(bus_a.frame_done), 32'd0);
    check({tag, "_busy"},       32'(bus_a.busy),       32'd0);
  endtask

  // ---------------- monitor for dut_b ----------------
  int          cyc_b = 0;
  logic        prev_clk_b = 1'b0, prev_data_b = 1'b0;
  int          run_b = 0, nbits_b = 0;
  int          phase_err_b = 0, stab_err_b = 0;
  logic [23:0] acc_b = '0;
  logic [23:0] lat_word_b [$];
  int          lat_bits_b [$];
  int          lat_cyc_b  [$];
  int          first_rise_b [$];

  always @(negedge clock) begin
    cyc_b++;
    if (bus_b.ser_clk != prev_clk_b) begin
      if (prev_clk_b) begin
        if (run_b != 3) phase_err_b++;
      end else if (nbits_b > 0 && run_b != 3) begin
        phase_err_b++;
      end
      run_b = 1;
    end else begin
      run_b++;
    end
    if (bus_b.ser_clk && !prev_clk_b) begin
      if (bus_b.ser_data != prev_data_b) stab_err_b++;
      if (nbits_b == 0) first_rise_b.push_back(cyc_b);
      acc_b = {acc_b[22:0], bus_b.ser_data};
      nbits_b++;
    end
    if (bus_b.ser_clk && prev_clk_b && bus_b.ser_data != prev_data_b) stab_err_b++;
    prev_clk_b  = bus_b.ser_clk;
    prev_data_b = bus_b.ser_data;
    if (bus_b.ser_latch) begin
      lat_word_b.push_back(acc_b);
      lat_bits_b.push_back(nbits_b);
      lat_cyc_b.push_back(cyc_b);
      acc_b   = '0;
      nbits_b = 0;
    end
  end

  function automatic logic [31:0] lw_b(input int i);
    return (i < lat_word_b.size()) ? 32'(lat_word_b[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic int lb_b(input int i);
    return (i < lat_bits_b.size()) ? lat_bits_b[i] : -1;
  endfunction
  function automatic int lc_b(input int i);
    return (i < lat_cyc_b.size()) ? lat_cyc_b[i] : -1000;
  endfunction
  function automatic int fr_b(input int i);
    return (i < first_rise_b.size()) ? first_rise_b[i] : -1000;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    bus_a.enable   = 1'b1;
    bus_a.board    = '0;
    bus_a.board[0] = 24'h800001;
    bus_b.enable   = 1'b1;
    bus_b.board    = '0;
    bus_b.board[0] = 24'hC3A55A;
    bus_b.board[1] = make_row(8'h81, 8'h7E, 8'h3C);

    // Reset held with enable high: everything quiet.
    repeat (3) tick();
    check_idle_a("rst");
    clear_a();
    lat_word_b.delete(); lat_bits_b.delete(); lat_cyc_b.delete(); first_rise_b.delete();
    acc_b = '0; nbits_b = 0; phase_err_b = 0; stab_err_b = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Single row: 24'h800001 shifted MSB first, one latch, 4-cycle hold, 54-cycle row.
    wait_lat_a(1, 200, "t2_lat0");
    check("t2_word", lw_a(0), 32'h0080_0001);
    check("t2_bits", 32'(lb_a(0)), 32'd24);
    check("t2_busy", 32'(bus_a.busy), 32'd1);
    wait_run_a(1, 50, "t2_hold");
    check("t2_sel", rs_a(0), 32'h01);
    check("t2_hold_len", 32'(rl_a(0)), 32'd4);
    wait_lat_a(2, 100, "t2_lat1");
    check("t2_row_period", 32'(lc_a(1) - lc_a(0)), 32'd54);
    check("t2_row1_word", lw_a(1), 32'h0);
    check("t2_latch_width", 32'(latch_long_a), 32'd0);

    // Walking rows: full frame reconstruction, row_sel walk, 432-cycle frame.
    reset_a = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) bus_a.board[i] = OLD_ROWS[i];
    clear_a();
    reset_a = 1'b0;
    wait_fd_a(2, 1200, "t3_fd");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_row%0d_word", i), lw_a(i), 32'(OLD_ROWS[i]));
      check($sformatf("t3_row%0d_sel", i), rs_a(i), 32'(8'd1 << i));
      check($sformatf("t3_row%0d_hold", i), 32'(rl_a(i)), 32'd4);
    end
    check("t3_frame_period", 32'(fd_a(1) - fd_a(0)), 32'd432);
    check("t3_onehot", 32'(multi_a), 32'd0);

    // Board changes during row 2: snapshot holds until the next frame.
    clear_a();
    wait_sel_a(8'h04, 300, "t4_row2");
    for (int i = 0; i < 8; i++) bus_a.board[i] = NEW_ROWS[i];
    wait_lat_a(10, 700, "t4_lat");
    for (int i = 3; i < 8; i++)
      check($sformatf("t4_snap_row%0d", i), lw_a(i), 32'(OLD_ROWS[i]));
    check("t4_next_row0", lw_a(8), 32'(NEW_ROWS[0]));
    check("t4_next_row1", lw_a(9), 32'(NEW_ROWS[1]));

    // Enable dropped during row 4: frame completes, then idle; re-enable restarts at row 0.
    clear_a();
    wait_fd_a(1, 600, "t5_sync");
    clear_a();
    wait_sel_a(8'h10, 400, "t5_row4");
    bus_a.enable = 1'b0;
    wait_fd_a(1, 400, "t5_fd");
    check("t5_fd_busy", 32'(bus_a.busy), 32'd0);
    check("t5_rows_latched", 32'(lat_word_a.size()), 32'd8);
    check("t5_last_sel", rs_a(7), 32'h80);
    repeat (60) tick();
    check("t5_idle_latches", 32'(lat_word_a.size()), 32'd8);
    check("t5_idle_busy", 32'(bus_a.busy), 32'd0);
    check("t5_idle_row_sel", 32'(bus_a.row_sel), 32'd0);
    bus_a.enable = 1'b1;
    clear_a();
    wait_run_a(1, 100, "t5_restart");
    check("t5_restart_sel", rs_a(0), 32'h01);
    check("t5_restart_word", lw_a(0), 32'(NEW_ROWS[0]));

    // One-cycle reset while row 3 is shifting.
    wait_sel_a(8'h04, 300, "t6_row2");
    wait_sel_a(8'h00, 20, "t6_row2_end");
    repeat (10) tick();
    check("t6_in_shift_busy", 32'(bus_a.busy), 32'd1);
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    check_idle_a("t6_rst");
    clear_a();
    wait_run_a(1, 100, "t6_restart");
    check("t6_restart_sel", rs_a(0), 32'h01);
    check("t6_restart_word", lw_a(0), 32'(NEW_ROWS[0]));

    // CLK_DIV=3 instance: 3-cycle phases, stable data, 144-cycle shift.
    check("b_row0_word", lw_b(0), 32'h00C3_A55A);
    check("b_row1_word", lw_b(1), 32'h003C_7E81);
    check("b_row0_bits", 32'(lb_b(0)), 32'd24);
    check("b_shift_span", 32'(lc_b(0) - fr_b(0)), 32'd141);
    check("b_row_period", 32'(lc_b(1) - lc_b(0)), 32'd150);
    check("b_phase_len", 32'(phase_err_b), 32'd0);
    check("b_data_stable", 32'(stab_err_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
